imem_uart_loader: RTL and testbench

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

---
 rtl/imem_uart_loader_pkg.sv | 15 +
 rtl/imem_uart_loader_if.sv | 11 +
 rtl/imem_uart_loader_uart_rx.sv | 87 ++++++++
 rtl/imem_uart_loader.sv | 111 +++++++++++
 tb/tb_imem_uart_loader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and header length.
package loader_pkg;

  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_uart_loader_if.sv
// Byte-stream link from the UART receiver to the loader FSM.
interface imem_uart_loader_if;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  modport master (output rx_byte, rx_valid, frame_err);
  modport slave  (input  rx_byte, rx_valid, frame_err);

endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver with input synchronizer, start-bit glitch rejection and framing check.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  imem_uart_loader_if.master rx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [1:0]    sync;
  logic          line;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign line = sync[1];

  // NOTE: every register here is updated with <= so all flops see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync         <= 2'b11;
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx.rx_byte   <= '0;
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], serial_in};
      rx.rx_valid  <= 1'b0;
      rx.frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!line) state <= RX_START;
        end
        RX_START: begin
          // Re-check mid start bit; a line already back high was only a glitch.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= line ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {line, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (line) begin
              rx.rx_byte  <= shreg;
              rx.rx_valid <= 1'b1;
            end else begin
              rx.frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a length-prefixed little-endian program over UART into instruction memory,
// holding the CPU in reset until the load completes.
module imem_uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_WORDS  = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           uart_rx,
  output logic                           imem_we,
  output logic [$clog2(DEPTH_WORDS)-1:0] imem_addr,
  output logic [31:0]                    imem_wdata,
  output logic                           cpu_reset,
  output logic                           done,
  output logic                           error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  imem_uart_loader_if rx_link ();

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .serial_in (uart_rx),
    .rx        (rx_link)
  );

  state_t                   state;
  logic [HDR_BYTES*8-1:0]   word_count;
  logic [HDR_BYTES*8-1:0]   words_done;
  logic [1:0]               byte_idx;
  logic [23:0]              word_buf;
  logic [HDR_BYTES*8-1:0]   hdr_count;
  logic                     last_word;

  assign hdr_count = {rx_link.rx_byte, word_count[7:0]};
  assign last_word = (words_done + 1'b1) == word_count;

  assign cpu_reset = (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign error     = (state == ST_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      word_count <= '0;
      words_done <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        ST_HDR0: begin
          if (rx_link.frame_err) begin
            state <= ST_ERR;
          end else if (rx_link.rx_valid) begin
            word_count[7:0] <= rx_link.rx_byte;
            state           <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (rx_link.frame_err) begin
            state <= ST_ERR;
          end else if (rx_link.rx_valid) begin
            word_count <= hdr_count;
            if (hdr_count == '0)
              state <= ST_DONE;
            else if ({16'd0, hdr_count} > 32'(DEPTH_WORDS))
              state <= ST_ERR;
            else
              state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_link.frame_err) begin
            state <= ST_ERR;
          end else if (rx_link.rx_valid) begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              // Header bound guarantees words_done < DEPTH_WORDS here.
              imem_we    <= 1'b1;
              imem_addr  <= words_done[AW-1:0];
              imem_wdata <= {rx_link.rx_byte, word_buf};
              words_done <= words_done + 1'b1;
              if (last_word) state <= ST_DONE;
            end else begin
              word_buf <= {rx_link.rx_byte, word_buf[23:8]};
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR: only start matters; received bytes are dropped.
          if (start) begin
            state      <= ST_HDR0;
            word_count <= '0;
            words_done <= '0;
            byte_idx   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench: serial byte driver, write monitor and a byte-stream reference model.
module tb_imem_uart_loader;

  localparam int CPB   = 4;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          uart_rx;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .uart_rx    (uart_rx),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [37:0] obs_q[$];
  logic [37:0] exp_q[$];
  logic [7:0]  stim_q[$];
  logic [31:0] mem [DEPTH];
  bit          exp_done;
  bit          exp_err;

  // Write monitor, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      obs_q.push_back({imem_addr, imem_wdata});
      mem[imem_addr] = imem_wdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_ok;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Reference: interpret the byte stream as a program image.
  task automatic model();
    int cnt;
    exp_q.delete();
    cnt      = int'(stim_q[0]) + 256 * int'(stim_q[1]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (cnt == 0) begin
      exp_done = 1'b1;
    end else if (cnt > DEPTH) begin
      exp_err = 1'b1;
    end else begin
      for (int w = 0; w < cnt; w++) begin
        logic [31:0] word;
        word = {stim_q[2 + 4*w + 3], stim_q[2 + 4*w + 2], stim_q[2 + 4*w + 1], stim_q[2 + 4*w]};
        exp_q.push_back({AW'(w), word});
      end
      exp_done = 1'b1;
    end
  endtask

  task automatic compare(input string tag);
    check($sformatf("%s.nwrites", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size())
        check($sformatf("%s.write%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check($sformatf("%s.done", tag), 64'(done), 64'(exp_done));
    check($sformatf("%s.error", tag), 64'(error), 64'(exp_err));
    check($sformatf("%s.cpu_reset", tag), 64'(cpu_reset), 64'(!exp_done));
  endtask

  task automatic run_load(input string tag);
    model();
    obs_q.delete();
    pulse_start();
    tick(2);
    check($sformatf("%s.busy_done", tag), 64'(done), 64'd0);
    check($sformatf("%s.busy_cpu_reset", tag), 64'(cpu_reset), 64'd1);
    foreach (stim_q[i]) send_byte(stim_q[i], 1'b1);
    tick(8);
    compare(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s.we", tag), 64'(imem_we), 64'd0);
    check($sformatf("%s.addr", tag), 64'(imem_addr), 64'd0);
    check($sformatf("%s.wdata", tag), 64'(imem_wdata), 64'd0);
    check($sformatf("%s.done", tag), 64'(done), 64'd0);
    check($sformatf("%s.error", tag), 64'(error), 64'd0);
    check($sformatf("%s.cpu_reset", tag), 64'(cpu_reset), 64'd1);
  endtask

  initial begin
    int cnt;
    reset   = 1'b1;
    start   = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    check_reset_outputs("por");
    reset = 1'b0;
    tick(4);

    // Single-cycle low pulse while idle must not produce a byte.
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(20);
    check("glitch.nwrites", 64'(obs_q.size()), 64'd0);
    check("glitch.done", 64'(done), 64'd0);
    check("glitch.error", 64'(error), 64'd0);

    stim_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h40, 8'h01};
    run_load("nominal");
    check("nominal.word0", 64'(mem[0]), 64'h0050_0513);
    check("nominal.word1", 64'(mem[1]), 64'h0140_0593);

    // A byte arriving in DONE has no effect.
    obs_q.delete();
    send_byte(8'hA5, 1'b1);
    tick(8);
    check("done_byte.nwrites", 64'(obs_q.size()), 64'd0);
    check("done_byte.done", 64'(done), 64'd1);

    stim_q = '{8'h00, 8'h00};
    run_load("zero");

    stim_q = '{8'h41, 8'h00};
    run_load("oversize65");

    stim_q = '{8'h40, 8'h00};
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
    stim_q[0] = 8'h01;
    run_load("count1");

    // Framing error on the third data byte aborts before any write.
    obs_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    tick(8);
    check("frame.nwrites", 64'(obs_q.size()), 64'd0);
    check("frame.error", 64'(error), 64'd1);
    check("frame.done", 64'(done), 64'd0);
    check("frame.cpu_reset", 64'(cpu_reset), 64'd1);

    for (int t = 0; t < 4; t++) begin
      cnt = int'($urandom_range(1, 4));
      stim_q = '{8'(cnt), 8'h00};
      for (int i = 0; i < 4 * cnt; i++) stim_q.push_back(8'($urandom));
      run_load($sformatf("rand%0d", t));
    end

    for (int t = 0; t < 2; t++) begin
      cnt = int'($urandom_range(65, 65535));
      stim_q = '{8'(cnt), 8'(cnt >> 8)};
      run_load($sformatf("rand_over%0d", t));
    end

    // Reset in the middle of DATA after one word has been written.
    obs_q.delete();
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    send_byte(8'h77, 1'b1);
    tick(4);
    check("midreset.nwrites", 64'(obs_q.size()), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    tick(2);
    reset = 1'b0;
    tick(4);
    check("midreset.kept", 64'(mem[0]), 64'hDEAD_BEEF);
    check("midreset.done_after", 64'(done), 64'd0);

    stim_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_load("reload");
    check("reload.word0", 64'(mem[0]), 64'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
